// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction word geometry, field offsets and the pack helper.
// Decode and the issue stage both take their field positions from here so the two can never
// disagree on the layout {alu_sig, oper1, oper2, dest}.
package pipe_pkg;

   localparam int unsigned ADDR_LEN = 5;
   localparam int unsigned INST_LEN = 2 + 3 * ADDR_LEN;

   // Field offsets inside the packed instruction word
   localparam int unsigned ALU_MSB  = 16;
   localparam int unsigned ALU_LSB  = 15;
   localparam int unsigned OP1_LSB  = 10;
   localparam int unsigned OP2_LSB  = 5;
   localparam int unsigned DEST_LSB = 0;

   typedef logic [ADDR_LEN-1:0] reg_addr_t;
   typedef logic [INST_LEN-1:0] inst_word_t;

   typedef struct packed {
      logic [1:0] alu_sig;
      reg_addr_t  oper1;
      reg_addr_t  oper2;
      reg_addr_t  dest;
   } inst_fields_t;

   function automatic inst_word_t pack_inst(input logic [1:0] alu_sig,
                                            input reg_addr_t  oper1,
                                            input reg_addr_t  oper2,
                                            input reg_addr_t  dest);
      inst_fields_t f;
      f.alu_sig = alu_sig;
      f.oper1   = oper1;
      f.oper2   = oper2;
      f.dest    = dest;
      return inst_word_t'(f);
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding packed instruction words between the loader and the issue logic.
// Ports:
//   clk, rstn       - clock, asynchronous active-low reset
//   push, wdata     - write request (ignored when full) and data
//   pop             - read request (ignored when empty); rdata shows the head
//   empty, full     - occupancy flags
//   count           - number of stored words, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W + 1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (PTR_W + 1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PTR_W + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read that matters
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/inst_issue.sv
// Instruction issue stage. Packs loader fields into instruction words, buffers them in a FIFO
// and issues one per cycle to decode, inserting a bubble while the head reads a register
// written by one of the last HAZARD_WIN issue slots.
// Ports:
//   clk, rstn                               - clock, asynchronous active-low reset
//   in_valid / in_ready                     - loader handshake
//   in_alu_sig, in_oper1, in_oper2, in_dest - instruction fields
//   run                                     - issue enable
//   inst, inst_valid                        - registered instruction to decode (0 = bubble)
//   stall                                   - registered; last slot was a hazard bubble
//   issued_cnt                              - wrapping count of issued instructions
module inst_issue #(
   parameter int unsigned INST_LEN   = pipe_pkg::INST_LEN,
   parameter int unsigned ADDR_LEN   = pipe_pkg::ADDR_LEN,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned HAZARD_WIN = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_alu_sig,
   input  logic [ADDR_LEN-1:0] in_oper1,
   input  logic [ADDR_LEN-1:0] in_oper2,
   input  logic [ADDR_LEN-1:0] in_dest,
   input  logic                run,
   output logic [INST_LEN-1:0] inst,
   output logic                inst_valid,
   output logic                stall,
   output logic [15:0]         issued_cnt
);

   import pipe_pkg::*;

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [INST_LEN-1:0] in_word, head;
   logic [ADDR_LEN-1:0] head_op1, head_op2, head_dest;
   logic                empty, full, unused_full;
   logic [CNT_W-1:0]    count;
   logic                push, issue, hazard;

   // Issue history, entry 0 is the most recent slot
   logic [HAZARD_WIN-1:0] hist_valid_q, hist_valid_d;
   logic [ADDR_LEN-1:0]   hist_dest_q [HAZARD_WIN];
   logic [ADDR_LEN-1:0]   hist_dest_d [HAZARD_WIN];

   logic [INST_LEN-1:0] inst_q;
   logic                inst_valid_q, stall_q;
   logic [15:0]         issued_cnt_q;

   assign in_word = pack_inst(in_alu_sig, in_oper1, in_oper2, in_dest);

   // Ready is not forwarded from a same-cycle pop, so a full FIFO always refuses
   assign in_ready    = (count < CNT_W'(FIFO_DEPTH));
   assign push        = in_valid && in_ready;
   assign unused_full = full;

   inst_fifo #(
      .WIDTH (INST_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .wdata (in_word),
      .pop   (issue),
      .rdata (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign head_op1  = head[OP1_LSB +: ADDR_LEN];
   assign head_op2  = head[OP2_LSB +: ADDR_LEN];
   assign head_dest = head[DEST_LSB +: ADDR_LEN];

   // Register 0 is an ordinary register here, so it takes part in the compare
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZARD_WIN; i++) begin
         if (hist_valid_q[i] && (hist_dest_q[i] == head_op1 || hist_dest_q[i] == head_op2)) begin
            hazard = 1'b1;
         end
      end
      if (empty) hazard = 1'b0;
   end

   assign issue = run && !empty && !hazard;

   // History shifts every cycle; bubbles enter as invalid slots so it drains when idle
   always_comb begin
      hist_valid_d    = hist_valid_q;
      hist_dest_d     = hist_dest_q;
      hist_valid_d[0] = issue;
      hist_dest_d[0]  = issue ? head_dest : '0;
      for (int i = 1; i < HAZARD_WIN; i++) begin
         hist_valid_d[i] = hist_valid_q[i-1];
         hist_dest_d[i]  = hist_dest_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist_valid_q <= '0;
         for (int i = 0; i < HAZARD_WIN; i++) hist_dest_q[i] <= '0;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         stall_q      <= 1'b0;
         issued_cnt_q <= '0;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_dest_q  <= hist_dest_d;
         inst_q       <= issue ? head : '0;
         inst_valid_q <= issue;
         stall_q      <= run && !empty && hazard;
         if (issue) issued_cnt_q <= issued_cnt_q + 16'd1;
      end
   end

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign stall      = stall_q;
   assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_inst_issue.sv
// Self-checking bench for inst_issue: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the issue stage.
module tb_inst_issue;

   localparam int unsigned AL = 5;
   localparam int unsigned IL = 17;
   localparam int unsigned FD = 4;
   localparam int unsigned HW = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_alu_sig;
   logic [AL-1:0] in_oper1, in_oper2, in_dest;
   logic          run;
   logic [IL-1:0] inst;
   logic          inst_valid;
   logic          stall;
   logic [15:0]   issued_cnt;

   always #5 clk = ~clk;

   inst_issue #(
      .INST_LEN   (IL),
      .ADDR_LEN   (AL),
      .FIFO_DEPTH (FD),
      .HAZARD_WIN (HW)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_alu_sig (in_alu_sig),
      .in_oper1   (in_oper1),
      .in_oper2   (in_oper2),
      .in_dest    (in_dest),
      .run        (run),
      .inst       (inst),
      .inst_valid (inst_valid),
      .stall      (stall),
      .issued_cnt (issued_cnt)
   );

   int checks = 0;
   int errors = 0;

   logic [IL-1:0] host_q[$];   // words the loader still has to hand over
   logic [IL-1:0] m_fifo[$];   // model of buffered words
   int            m_hist[$];   // recent issue slots, front = newest, -1 = bubble
   logic [IL-1:0] m_inst;
   logic          m_valid, m_stall;
   logic [15:0]   m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [IL-1:0] mk(input int alu, input int o1, input int o2, input int d);
      return {alu[1:0], o1[4:0], o2[4:0], d[4:0]};
   endfunction

   function automatic void m_reset();
      m_fifo.delete();
      m_hist.delete();
      for (int i = 0; i < HW; i++) m_hist.push_back(-1);
      m_inst  = '0;
      m_valid = 1'b0;
      m_stall = 1'b0;
      m_cnt   = '0;
   endfunction

   function automatic bit m_hazard();
      logic [IL-1:0] h;
      int o1, o2;
      if (m_fifo.size() == 0) return 1'b0;
      h  = m_fifo[0];
      o1 = int'(h[14:10]);
      o2 = int'(h[9:5]);
      foreach (m_hist[i]) begin
         if (m_hist[i] >= 0 && (m_hist[i] == o1 || m_hist[i] == o2)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // One clock edge of the model, given this cycle's run and accepted word
   function automatic void model_edge(input bit acc, input logic [IL-1:0] w);
      bit nonempty, hz;
      nonempty = (m_fifo.size() > 0);
      hz       = m_hazard();
      if (run && nonempty && !hz) begin
         m_inst  = m_fifo.pop_front();
         m_valid = 1'b1;
         m_stall = 1'b0;
         m_cnt   = m_cnt + 16'd1;
         m_hist.push_front(int'(m_inst[4:0]));
      end else begin
         m_inst  = '0;
         m_valid = 1'b0;
         m_stall = run && nonempty && hz;
         m_hist.push_front(-1);
      end
      while (m_hist.size() > HW) void'(m_hist.pop_back());
      if (acc) m_fifo.push_back(w);
   endfunction

   // Called just after a falling edge; drives one cycle and checks the result
   task automatic tick(input bit valid_en);
      logic [IL-1:0] w;
      bit acc;
      if (valid_en && host_q.size() > 0) begin
         in_valid = 1'b1;
         w        = host_q[0];
      end else begin
         in_valid = 1'b0;
         w        = IL'($urandom);
      end
      {in_alu_sig, in_oper1, in_oper2, in_dest} = w;
      #1;
      check_eq("in_ready", 32'(in_ready), 32'(m_fifo.size() < FD));
      acc = in_valid && (m_fifo.size() < FD);
      model_edge(acc, w);
      if (acc) void'(host_q.pop_front());
      @(posedge clk);
      @(negedge clk);
      check_eq("inst", 32'(inst), 32'(m_inst));
      check_eq("inst_valid", 32'(inst_valid), 32'(m_valid));
      check_eq("stall", 32'(stall), 32'(m_stall));
      check_eq("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
   endtask

   logic [IL-1:0] rec_inst [10];
   logic          rec_valid[10];
   logic          rec_stall[10];
   logic [IL-1:0] words[8];
   logic [15:0]   cnt_start;
   int            n_a, issued, guard;

   initial begin
      rstn       = 1'b0;
      in_valid   = 1'b0;
      run        = 1'b0;
      in_alu_sig = '0;
      in_oper1   = '0;
      in_oper2   = '0;
      in_dest    = '0;
      m_reset();
      @(negedge clk);
      check_eq("rst_inst", 32'(inst), 32'h0);
      check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
      check_eq("rst_stall", 32'(stall), 32'h0);
      check_eq("rst_issued_cnt", 32'(issued_cnt), 32'h0);
      check_eq("rst_in_ready", 32'(in_ready), 32'h1);
      rstn = 1'b1;

      // Single instruction, one-cycle latency
      run = 1'b1;
      host_q.push_back(mk(1, 1, 2, 3));
      tick(1'b1);
      tick(1'b1);
      check_eq("single_inst", 32'(inst), 32'(17'b01_00001_00010_00011));
      check_eq("single_valid", 32'(inst_valid), 32'h1);
      check_eq("single_cnt", 32'(issued_cnt), 32'h1);

      // Dependent pair costs two bubbles
      repeat (3) tick(1'b0);
      words[0] = mk(0, 10, 11, 3);
      words[1] = mk(2, 3, 12, 4);
      host_q.push_back(words[0]);
      host_q.push_back(words[1]);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1);
         rec_inst[i]  = inst;
         rec_valid[i] = inst_valid;
         rec_stall[i] = stall;
      end
      n_a = -1;
      for (int i = 7; i >= 0; i--) if (rec_valid[i] && rec_inst[i] == words[0]) n_a = i;
      if (n_a < 0 || n_a > 4) begin
         check_eq("dep_a_issued", 32'(n_a), 32'd1);
      end else begin
         check_eq("dep_bubble1_stall", 32'(rec_stall[n_a+1]), 32'h1);
         check_eq("dep_bubble1_valid", 32'(rec_valid[n_a+1]), 32'h0);
         check_eq("dep_bubble2_stall", 32'(rec_stall[n_a+2]), 32'h1);
         check_eq("dep_bubble2_valid", 32'(rec_valid[n_a+2]), 32'h0);
         check_eq("dep_b_inst", 32'(rec_inst[n_a+3]), 32'(words[1]));
         check_eq("dep_b_valid", 32'(rec_valid[n_a+3]), 32'h1);
      end

      // Independent stream: one issue per cycle, in order
      repeat (3) tick(1'b0);
      for (int k = 0; k < 8; k++) begin
         words[k] = mk(k % 4, 8 + k, 9 + k, 20 + k);
         host_q.push_back(words[k]);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b1);
         rec_inst[i]  = inst;
         rec_valid[i] = inst_valid;
      end
      for (int k = 0; k < 8; k++) begin
         check_eq("stream_valid", 32'(rec_valid[k+1]), 32'h1);
         check_eq("stream_order", 32'(rec_inst[k+1]), 32'(words[k]));
      end

      // Fill while stalled: fifth word waits at the host
      run       = 1'b0;
      cnt_start = m_cnt;
      for (int k = 0; k < 5; k++) host_q.push_back(mk(3, 1 + k, 2 + k, 24 + k));
      repeat (5) tick(1'b1);
      check_eq("full_ready_low", 32'(in_ready), 32'h0);
      check_eq("full_no_issue", 32'(issued_cnt), 32'(cnt_start));
      run = 1'b1;
      repeat (8) tick(1'b1);
      check_eq("full_drained_cnt", 32'(issued_cnt), 32'(cnt_start + 16'd5));

      // Asynchronous reset with work in flight
      repeat (3) tick(1'b0);
      run = 1'b0;
      for (int k = 0; k < 4; k++) host_q.push_back(mk(1, 1 + k, 2 + k, 10 + k));
      repeat (4) tick(1'b1);
      run = 1'b1;
      tick(1'b1);
      check_eq("pre_rst_valid", 32'(inst_valid), 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("async_rst_inst", 32'(inst), 32'h0);
      check_eq("async_rst_valid", 32'(inst_valid), 32'h0);
      check_eq("async_rst_cnt", 32'(issued_cnt), 32'h0);
      check_eq("async_rst_ready", 32'(in_ready), 32'h1);
      m_reset();
      host_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      repeat (6) tick(1'b1);
      check_eq("post_rst_cnt", 32'(issued_cnt), 32'h0);

      // Randomized traffic with a small register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         if (host_q.size() < 2 && $urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 7) == 0) begin
               host_q.push_back(IL'($urandom));
            end else begin
               host_q.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3),
                                   $urandom_range(0, 3), $urandom_range(0, 3)));
            end
         end
         run = ($urandom_range(0, 3) != 0);
         tick($urandom_range(0, 3) != 0);
      end

      // Counter wrap after 65536 issues
      run       = 1'b1;
      cnt_start = m_cnt;
      issued    = 0;
      guard     = 0;
      while (issued < 65536 && guard < 70000) begin
         if (host_q.size() < 2) host_q.push_back(mk(1, 0, 0, 31));
         tick(1'b1);
         if (m_valid) issued++;
         guard++;
      end
      check_eq("wrap_issued", 32'(issued), 32'd65536);
      check_eq("wrap_cnt", 32'(issued_cnt), 32'(cnt_start));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
